// File: rtl/wb_ram_banked_if.sv
// Bus bundle between a Wishbone master and the banked RAM slave.
//
// Handshake: the master raises cyc and stb together to offer a request
// (stb is the "valid"); the slave signals it is able to service requests
// with ready = 1. A request is accepted on the first rising edge where the
// slave is idle, ready = 1 and cyc & stb = 1. Exactly one completion follows
// each accepted request: either a one-cycle ack (with data_read valid for
// reads) or a one-cycle err. Dropping cyc before completion aborts the
// transfer silently. Requests offered while ready = 0 are not accepted.
//
// Signals: cyc, stb, we, addr, width, data_write (master -> slave);
//          data_read, ack, err, ready (slave -> master).
interface wb_ram_banked_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        width;
    logic [31:0]       data_write;
    logic [31:0]       data_read;
    logic              ack;
    logic              err;
    logic              ready;

    modport master (
        output cyc, stb, we, addr, width, data_write,
        input  data_read, ack, err, ready
    );

    modport slave (
        input  cyc, stb, we, addr, width, data_write,
        output data_read, ack, err, ready
    );
endinterface

// File: rtl/wb_ram_banked.sv
// Banked on-chip RAM slave for the Wishbone bus.
// Storage is four byte lanes of DEPTH/4 words each, with registered reads so
// every lane maps onto a block RAM. Adds base-address decode, misalignment
// and range errors, configurable wait states and a post-reset clear engine.
//
// Ports:
//   iClk    - system clock, rising edge
//   iRst    - asynchronous active-low reset
//   bus     - slave side of wb_ram_banked_if (cyc/stb/we/addr/width/
//             data_write in; data_read/ack/err/ready out)
//   state_o - current FSM state, for debug and checker binding
module wb_ram_banked #(
    parameter int unsigned       DEPTH          = 4096,
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int unsigned       WAIT_STATES    = 0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    wb_ram_banked_if.slave        bus,
    output logic [2:0]            state_o
);
    localparam int unsigned WORDS = DEPTH / 4;
    localparam int unsigned WA    = $clog2(WORDS);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [WA-1:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [1:0]  width_q, width_d;
    logic [1:0]  off_q, off_d;

    // Request decode, evaluated straight from the bus in the accept cycle.
    logic [ADDR_W-1:0] offset;
    logic              req;
    logic              in_range;
    logic              misalign;
    logic              bad;
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic              clr_we;
    logic [WA-1:0]     word_idx;
    logic [3:0]        lane_en;
    logic [31:0]       wdata;
    logic [31:0]       rd_word;
    logic [31:0]       shifted;

    // Unsigned wrap makes addresses below BASE_ADDR land far above DEPTH,
    // so one compare covers both ends of the window.
    assign offset   = bus.addr - BASE_ADDR;
    assign in_range = offset < ADDR_W'(DEPTH);
    assign misalign = (bus.width == 2'b01 && offset[0]) ||
                      (bus.width[1] && offset[1:0] != 2'b00);
    assign bad      = !in_range || misalign;
    assign req      = bus.cyc & bus.stb;
    assign accept   = (state_q == S_IDLE) && req;
    assign wr_en    = accept && !bad && bus.we;
    assign rd_en    = accept && !bad && !bus.we;
    assign clr_we   = (state_q == S_CLEAR);
    assign word_idx = offset[WA+1:2];

    always_comb begin
        lane_en = 4'b0000;
        wdata   = {4{bus.data_write[7:0]}};
        if (bus.width[1]) begin
            lane_en = 4'b1111;
            wdata   = bus.data_write;
        end else if (bus.width[0]) begin
            lane_en = 4'b0011 << offset[1:0];
            wdata   = {2{bus.data_write[15:0]}};
        end else begin
            lane_en = 4'b0001 << offset[1:0];
        end
    end

    // One RAM per byte lane; the clear engine has priority over bus writes
    // (bus requests are never accepted while clearing anyway).
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] mem_q [WORDS];
        logic [7:0] rd_lane_q;

        always_ff @(posedge iClk) begin
            if (clr_we) begin
                mem_q[clr_cnt_q] <= 8'h00;
            end else if (wr_en && lane_en[k]) begin
                mem_q[word_idx] <= wdata[8*k +: 8];
            end
            if (rd_en) begin
                rd_lane_q <= mem_q[word_idx];
            end
        end

        assign rd_word[8*k +: 8] = rd_lane_q;
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        ready_d    = ready_q;
        we_d       = we_q;
        width_d    = width_q;
        off_d      = off_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + WA'(1);
                if (clr_cnt_q == WA'(WORDS - 1)) begin
                    clr_cnt_d = '0;
                    ready_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req) begin
                    we_d       = bus.we;
                    width_d    = bus.width;
                    off_d      = offset[1:0];
                    wait_cnt_d = 2'd0;
                    if (bad) begin
                        state_d = S_ERR;
                    end else if (WAIT_STATES != 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                // The write (if any) already landed at accept; aborting only
                // suppresses the ack.
                if (!bus.cyc) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == 2'(WAIT_STATES - 1)) begin
                    state_d = S_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clr_cnt_q  <= '0;
            wait_cnt_q <= 2'd0;
            ready_q    <= !CLEAR_ON_RESET;
            we_q       <= 1'b0;
            width_q    <= 2'b00;
            off_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            width_q    <= width_d;
            off_q      <= off_d;
        end
    end

    // Little-endian: the addressed byte moves down to bit 0, then the
    // access width masks off the lanes that were not requested.
    assign shifted = rd_word >> {off_q, 3'b000};

    always_comb begin
        bus.data_read = 32'h0000_0000;
        if (state_q == S_ACK && !we_q) begin
            if (width_q[1]) begin
                bus.data_read = shifted;
            end else if (width_q[0]) begin
                bus.data_read = {16'h0000, shifted[15:0]};
            end else begin
                bus.data_read = {24'h00_0000, shifted[7:0]};
            end
        end
    end

    assign bus.ack   = (state_q == S_ACK);
    assign bus.err   = (state_q == S_ERR);
    assign bus.ready = ready_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_wb_ram_banked.sv
module tb_wb_ram_banked;
    localparam int          D0   = 4096;
    localparam int          D2   = 1024;
    localparam logic [31:0] B0   = 32'h0000_0000;
    localparam logic [31:0] B2   = 32'h8000_0000;
    localparam int          WS0  = 0;
    localparam int          WS2  = 2;
    localparam int          CLR0 = D0 / 4;
    localparam int          CLR2 = D2 / 4;

    typedef struct {
        int          due;
        bit          is_err;
        logic [31:0] data;
    } resp_t;

    // ---------------- clock / reset ----------------
    logic iClk = 1'b0;
    logic iRst = 1'b0;
    always #5 iClk = ~iClk;

    int cyc_n = 0;
    int rel_n = 1 << 30;
    always @(posedge iClk) cyc_n <= cyc_n + 1;

    wb_ram_banked_if #(.ADDR_W(32)) bus0 ();
    wb_ram_banked_if #(.ADDR_W(32)) bus2 ();
    logic [2:0] st0, st2;

    wb_ram_banked #(.DEPTH(D0), .ADDR_W(32), .BASE_ADDR(B0),
                    .WAIT_STATES(WS0), .CLEAR_ON_RESET(1'b1)) dut0 (
        .iClk(iClk), .iRst(iRst), .bus(bus0), .state_o(st0));

    wb_ram_banked #(.DEPTH(D2), .ADDR_W(32), .BASE_ADDR(B2),
                    .WAIT_STATES(WS2), .CLEAR_ON_RESET(1'b1)) dut2 (
        .iClk(iClk), .iRst(iRst), .bus(bus2), .state_o(st2));

    // ---------------- model ----------------
    // Byte-addressed images of the two memories (both cleared after reset).
    logic [7:0] m0 [D0];
    logic [7:0] m2 [D2];
    resp_t      exp_q0 [$];
    resp_t      exp_q2 [$];
    int checks = 0;
    int errors = 0;

    // Applies one accepted request to the model and returns the response the
    // bus must show, with the cycle number it must be visible in.
    function automatic resp_t model_req(input int sel, input bit w,
                                        input logic [31:0] a, input logic [1:0] wd,
                                        input logic [31:0] d, input int acc);
        resp_t  r;
        longint base, off;
        int     depth, ws, n;
        base  = (sel == 0) ? longint'(B0) : longint'(B2);
        depth = (sel == 0) ? D0 : D2;
        ws    = (sel == 0) ? WS0 : WS2;
        n     = wd[1] ? 4 : (wd[0] ? 2 : 1);
        off   = longint'(a) - base;
        r.data = 32'h0;
        if (off < 0 || off >= longint'(depth) || (off % n) != 0) begin
            r.is_err = 1'b1;
            r.due    = acc;
        end else begin
            r.is_err = 1'b0;
            r.due    = acc + ws;
            for (int k = 0; k < n; k++) begin
                if (w) begin
                    if (sel == 0) m0[int'(off) + k] = d[8*k +: 8];
                    else          m2[int'(off) + k] = d[8*k +: 8];
                end else begin
                    r.data[8*k +: 8] = (sel == 0) ? m0[int'(off) + k] : m2[int'(off) + k];
                end
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard: every cycle, both instances ----------------
    task automatic check_one(input int sel, input logic ack, input logic err,
                             input logic [31:0] dr, input logic rdy);
        logic        e_ack, e_err, e_rdy;
        logic [31:0] e_d;
        resp_t       r;
        bit          have;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_d   = 32'h0;
        have  = 1'b0;
        e_rdy = iRst && (cyc_n >= rel_n + ((sel == 0) ? CLR0 : CLR2));
        if (sel == 0 && exp_q0.size() > 0 && exp_q0[0].due <= cyc_n) begin
            r = exp_q0.pop_front();
            have = 1'b1;
        end else if (sel == 2 && exp_q2.size() > 0 && exp_q2[0].due <= cyc_n) begin
            r = exp_q2.pop_front();
            have = 1'b1;
        end
        if (have) begin
            e_ack = !r.is_err;
            e_err = r.is_err;
            e_d   = r.data;
        end
        checks++;
        if ({ack, err, dr, rdy} !== {e_ack, e_err, e_d, e_rdy}) begin
            errors++;
            $display("FAIL bus%0d cycle %0d: ack/err/data/ready got %b/%b/%h/%b expected %b/%b/%h/%b",
                     sel, cyc_n, ack, err, dr, rdy, e_ack, e_err, e_d, e_rdy);
        end
    endtask

    always @(negedge iClk) begin
        check_one(0, bus0.ack, bus0.err, bus0.data_read, bus0.ready);
        check_one(2, bus2.ack, bus2.err, bus2.data_read, bus2.ready);
    end

    // ---------------- drivers ----------------
    task automatic drive(input int sel, input logic c, input logic w,
                         input logic [31:0] a, input logic [1:0] wd, input logic [31:0] d);
        if (sel == 0) begin
            bus0.cyc = c; bus0.stb = c; bus0.we = w;
            bus0.addr = a; bus0.width = wd; bus0.data_write = d;
        end else begin
            bus2.cyc = c; bus2.stb = c; bus2.we = w;
            bus2.addr = a; bus2.width = wd; bus2.data_write = d;
        end
    endtask

    // Full transfer: cyc/stb stay high through the completion cycle and one
    // cycle past it, so a slave that re-accepts in ACK shows up as an
    // unexpected pulse.
    task automatic do_req(input int sel, input bit w, input logic [31:0] a,
                          input logic [1:0] wd, input logic [31:0] d,
                          output logic [31:0] got, output logic got_err);
        resp_t r;
        int    acc;
        @(negedge iClk);
        drive(sel, 1'b1, w, a, wd, d);
        acc = cyc_n + 1;
        r = model_req(sel, w, a, wd, d, acc);
        if (sel == 0) exp_q0.push_back(r);
        else          exp_q2.push_back(r);
        do @(negedge iClk); while (cyc_n < r.due);
        got     = (sel == 0) ? bus0.data_read : bus2.data_read;
        got_err = (sel == 0) ? bus0.err : bus2.err;
        @(negedge iClk);
        drive(sel, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout at cycle %0d (states %0d/%0d)", cyc_n, st0, st2);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] got;
        logic        ge;
        resp_t       dummy;
        int          acc;

        drive(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        for (int i = 0; i < D0; i++) m0[i] = 8'h00;
        for (int i = 0; i < D2; i++) m2[i] = 8'h00;

        repeat (3) @(negedge iClk);
        chk("reset ack", {31'h0, bus0.ack}, 32'h0);
        chk("reset ready", {31'h0, bus0.ready}, 32'h0);
        iRst  = 1'b1;
        rel_n = cyc_n;

        // Request while clearing: must be ignored entirely.
        drive(0, 1'b1, 1'b0, 32'h0, 2'b10, 32'h0);
        repeat (5) @(negedge iClk);
        drive(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);

        while (cyc_n < rel_n + CLR2 - 1) @(negedge iClk);
        chk("bus2 ready at 255", {31'h0, bus2.ready}, 32'h0);
        @(negedge iClk);
        chk("bus2 ready at 256", {31'h0, bus2.ready}, 32'h1);
        while (cyc_n < rel_n + CLR0 - 1) @(negedge iClk);
        chk("bus0 ready at 1023", {31'h0, bus0.ready}, 32'h0);
        @(negedge iClk);
        chk("bus0 ready at 1024", {31'h0, bus0.ready}, 32'h1);

        // WAIT_STATES = 0 instance
        do_req(0, 0, 32'h000, 2'b10, 32'h0, got, ge);
        chk("read 0x000 after clear", got, 32'h0000_0000);
        do_req(0, 1, 32'h010, 2'b10, 32'hDEAD_BEEF, got, ge);
        chk("write 0x10 err", {31'h0, ge}, 32'h0);
        do_req(0, 0, 32'h010, 2'b00, 32'h0, got, ge);
        chk("byte 0x10", got, 32'h0000_00EF);
        do_req(0, 0, 32'h011, 2'b00, 32'h0, got, ge);
        chk("byte 0x11", got, 32'h0000_00BE);
        do_req(0, 0, 32'h012, 2'b00, 32'h0, got, ge);
        chk("byte 0x12", got, 32'h0000_00AD);
        do_req(0, 0, 32'h013, 2'b00, 32'h0, got, ge);
        chk("byte 0x13", got, 32'h0000_00DE);
        do_req(0, 0, 32'h012, 2'b01, 32'h0, got, ge);
        chk("half 0x12", got, 32'h0000_DEAD);
        do_req(0, 1, 32'h020, 2'b10, 32'h5566_7788, got, ge);
        do_req(0, 1, 32'h022, 2'b01, 32'hFFFF_1234, got, ge);
        do_req(0, 0, 32'h020, 2'b10, 32'h0, got, ge);
        chk("word 0x20 after half", got, 32'h1234_7788);
        do_req(0, 1, 32'h021, 2'b00, 32'h0000_00AB, got, ge);
        do_req(0, 0, 32'h020, 2'b11, 32'h0, got, ge);
        chk("word 0x20 after byte", got, 32'h1234_AB88);

        do_req(0, 0, 32'h021, 2'b10, 32'h0, got, ge);
        chk("misaligned word err", {31'h0, ge}, 32'h1);
        do_req(0, 0, 32'h013, 2'b01, 32'h0, got, ge);
        chk("misaligned half err", {31'h0, ge}, 32'h1);
        do_req(0, 1, 32'h1001, 2'b10, 32'hFFFF_FFFF, got, ge);
        chk("write 0x1001 err", {31'h0, ge}, 32'h1);
        do_req(0, 1, 32'h1000, 2'b10, 32'hFFFF_FFFF, got, ge);
        chk("write 0x1000 err", {31'h0, ge}, 32'h1);
        do_req(0, 0, 32'h000, 2'b10, 32'h0, got, ge);
        chk("word 0x000 unchanged", got, 32'h0000_0000);
        do_req(0, 0, 32'hFFF, 2'b00, 32'h0, got, ge);
        chk("last byte ok", {31'h0, ge}, 32'h0);

        // WAIT_STATES = 2 instance at a non-zero base
        do_req(2, 1, B2 + 32'h40, 2'b10, 32'hA5A5_0001, got, ge);
        do_req(2, 0, B2 + 32'h40, 2'b10, 32'h0, got, ge);
        chk("ws2 word 0x40", got, 32'hA5A5_0001);
        do_req(2, 0, B2 + 32'h42, 2'b01, 32'h0, got, ge);
        chk("ws2 half 0x42", got, 32'h0000_A5A5);
        do_req(2, 0, B2 + 32'h40, 2'b00, 32'h0, got, ge);
        chk("ws2 byte 0x40", got, 32'h0000_0001);
        do_req(2, 0, B2 - 32'h4, 2'b10, 32'h0, got, ge);
        chk("ws2 below base err", {31'h0, ge}, 32'h1);
        do_req(2, 0, B2 + 32'h400, 2'b10, 32'h0, got, ge);
        chk("ws2 above top err", {31'h0, ge}, 32'h1);

        // Abort a write during WAIT: no completion, data still committed.
        @(negedge iClk);
        drive(2, 1'b1, 1'b1, B2 + 32'h80, 2'b10, 32'h1122_3344);
        acc = cyc_n + 1;
        dummy = model_req(2, 1'b1, B2 + 32'h80, 2'b10, 32'h1122_3344, acc);
        @(negedge iClk);
        drive(2, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        repeat (4) @(negedge iClk);
        do_req(2, 0, B2 + 32'h80, 2'b10, 32'h0, got, ge);
        chk("ws2 read after abort", got, 32'h1122_3344);
        chk("abort model agrees", got, dummy.is_err ? 32'h0 : 32'h1122_3344);

        repeat (4) @(negedge iClk);
        chk("queue0 drained", exp_q0.size(), 32'h0);
        chk("queue2 drained", exp_q2.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_ram_banked.md
Name: wb_ram_banked

Overview:
- Next-generation on-chip RAM slave for the Wishbone memory bus.
- Registered, block-RAM-friendly storage organised as four byte lanes of DEPTH/4 words.
- Adds configurable wait states, base-address decode, misalignment and range error reporting, and an optional post-reset clear engine.
- Sits behind the bus interconnect as instruction or data memory for the core.

Parameters:
- DEPTH, 4096, memory size in bytes; power of two, multiple of 4.
- ADDR_W, 32, bus address width.
- BASE_ADDR, 32'h0000_0000, first byte address decoded by this block; aligned to DEPTH.
- WAIT_STATES, 0, extra cycles (0..3) inserted between accept and ack.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset release; 0 = contents undefined after power-up and retained across reset.

Ports:
- iClk  in  1  system clock; all state changes on rising edge.
- iRst  in  1  asynchronous, active-low reset.
- cyc  in  1  bus cycle valid.
- stb  in  1  transfer strobe.
- we  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  byte address.
- width  in  2  access size: 00 = byte, 01 = half, 1x = word.
- data_write  in  32  write data, right-justified (byte in [7:0], half in [15:0]).
- data_read  out  32  read data, zero-extended, valid only while ack = 1.
- ack  out  1  one-cycle successful completion pulse.
- err  out  1  one-cycle error completion pulse.
- ready  out  1  1 = clear engine finished, requests serviced.

Behaviour:
- Reset (iRst = 0, asynchronous):
  - ack = 0, err = 0, data_read = 0.
  - ready = 0 if CLEAR_ON_RESET, else 1.
  - FSM goes to CLEAR if CLEAR_ON_RESET, else IDLE.
  - Memory array is not reset.
- States:
  - CLEAR: writes 0 to word index clr_cnt in all lanes each cycle, clr_cnt 0 .. DEPTH/4-1. After the last word, goes to IDLE and ready = 1. Requests are ignored (no ack/err) during CLEAR.
  - IDLE: on cyc & stb, latches we, width, offset = addr - BASE_ADDR, and data_write, then classifies the request:
    - Error if the address is out of range: addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH.
    - Error if the access is misaligned: half with offset[0] = 1, or word with offset[1:0] != 0.
    - Errored request -> ERR.
    - Valid write: byte lanes are enabled per width and offset[1:0] and written in the accept cycle -> WAIT if WAIT_STATES > 0, else ACK.
    - Valid read: RAM read issued in the accept cycle -> WAIT or ACK.
  - WAIT: counts WAIT_STATES cycles, then -> ACK. If cyc drops, abort -> IDLE with no ack; a committed write stays committed.
  - ACK: ack = 1 for exactly one cycle.
    - Reads: data_read holds the registered lane data shifted down by offset[1:0] and zero-extended to 32 bits.
    - Writes: data_read = 0.
    - Next state is IDLE. stb held high in this cycle does not start a new transfer.
  - ERR: err = 1 for one cycle, no memory write, data_read = 0 -> IDLE.
- Timing:
  - Latency from accept to ack = 1 + WAIT_STATES cycles.
  - Minimum transfer period = 2 + WAIT_STATES cycles.
- Byte order is little-endian: byte at offset k is in lane k[1:0].
- ack and err are never high together; neither is ever high while ready = 0.
- If reset is asserted mid-transfer, the transfer is dropped; a write already committed remains.

Test Plan:
- Reset release with CLEAR_ON_RESET = 1, DEPTH = 4096 -> ready rises exactly 1024 cycles after iRst rises; a read of word 0x000 then returns 0x0000_0000.
- Word write 0xDEADBEEF at 0x10, then byte reads at 0x10..0x13 (WAIT_STATES = 0) -> 0xEF, 0xBE, 0xAD, 0xDE; each ack arrives 1 cycle after accept.
- Half write 0x1234 at 0x22, then word read at 0x20 -> 0x1234_xxxx, with the low half unchanged from the prior value.
- Word read at 0x21 and half read at 0x13 -> err pulse for 1 cycle, no ack; a word write at 0x1001 with DEPTH = 4096 -> err, memory unchanged.
- WAIT_STATES = 2, write then read 0xA5A5_0001 at 0x40 -> ack 3 cycles after each accept; read data matches.
- cyc deasserted during WAIT of a write -> no ack; a subsequent read shows the new data. A request issued while ready = 0 -> no response until cleared, re-issue after ready succeeds.
